// File: rtl/fwd_pkg.sv
// Shared encodings for the operand-forwarding and hazard-control block.
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam int unsigned REG_X0 = 0;

  typedef enum logic [0:0] {
    StIdle,
    StLuStall
  } hz_state_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the pipeline, slave the hazard unit.
interface fwd_hazard_unit_if #(
  parameter int unsigned WIDTH_SOURCE = 5,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned CNT_W        = 16
);
  logic [NUM_SRC*WIDTH_SOURCE-1:0] ID_rs;
  logic [NUM_SRC-1:0]              ID_rs_used;
  logic [NUM_SRC*WIDTH_SOURCE-1:0] ID_EX_rs;
  logic [WIDTH_SOURCE-1:0]         ID_EX_rd;
  logic                            ID_EX_Reg_Wr;
  logic                            ID_EX_Mem_Rd;
  logic [WIDTH_SOURCE-1:0]         EX_MEM_rd;
  logic                            EX_MEM_Reg_Wr;
  logic                            EX_MEM_Mem_Acc;
  logic [WIDTH_SOURCE-1:0]         MEM_WB_rd;
  logic                            MEM_WB_Reg_Wr;
  logic                            mem_ready;
  logic                            stall_cnt_clr;
  logic [2*NUM_SRC-1:0]            Forward;
  logic                            PC_Stall;
  logic                            IF_ID_Stall;
  logic                            ID_EX_Flush;
  logic                            Pipe_Freeze;
  logic [CNT_W-1:0]                stall_cnt;

  modport master (
    output ID_rs, ID_rs_used, ID_EX_rs, ID_EX_rd, ID_EX_Reg_Wr, ID_EX_Mem_Rd,
    output EX_MEM_rd, EX_MEM_Reg_Wr, EX_MEM_Mem_Acc, MEM_WB_rd, MEM_WB_Reg_Wr,
    output mem_ready, stall_cnt_clr,
    input  Forward, PC_Stall, IF_ID_Stall, ID_EX_Flush, Pipe_Freeze, stall_cnt
  );

  modport slave (
    input  ID_rs, ID_rs_used, ID_EX_rs, ID_EX_rd, ID_EX_Reg_Wr, ID_EX_Mem_Rd,
    input  EX_MEM_rd, EX_MEM_Reg_Wr, EX_MEM_Mem_Acc, MEM_WB_rd, MEM_WB_Reg_Wr,
    input  mem_ready, stall_cnt_clr,
    output Forward, PC_Stall, IF_ID_Stall, ID_EX_Flush, Pipe_Freeze, stall_cnt
  );
endinterface

// File: rtl/fwd_src_sel.sv
// Per-source comparator: forwarding select for the EX operand and load-use match for ID.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int unsigned WIDTH_SOURCE = 5
) (
  input  logic [WIDTH_SOURCE-1:0] ex_rs,
  input  logic [WIDTH_SOURCE-1:0] ex_mem_rd,
  input  logic                    ex_mem_reg_wr,
  input  logic [WIDTH_SOURCE-1:0] mem_wb_rd,
  input  logic                    mem_wb_reg_wr,
  input  logic [WIDTH_SOURCE-1:0] id_rs,
  input  logic                    id_rs_used,
  input  logic [WIDTH_SOURCE-1:0] id_ex_rd,
  output logic [1:0]              fwd_sel,
  output logic                    lu_match
);

  localparam logic [WIDTH_SOURCE-1:0] X0 = WIDTH_SOURCE'(REG_X0);

  logic hit_exmem, hit_memwb;

  assign hit_exmem = ex_mem_reg_wr && (ex_mem_rd != X0) && (ex_mem_rd == ex_rs);
  assign hit_memwb = mem_wb_reg_wr && (mem_wb_rd != X0) && (mem_wb_rd == ex_rs);

  // The younger result in EX/MEM wins over MEM/WB.
  always_comb begin
    fwd_sel = FWD_RF;
    if (hit_exmem) begin
      fwd_sel = FWD_EXMEM;
    end else if (hit_memwb) begin
      fwd_sel = FWD_MEMWB;
    end
  end

  assign lu_match = id_rs_used && (id_ex_rd != X0) && (id_rs == id_ex_rd);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use bubble insertion, memory freeze and stall-cycle counting.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned WIDTH_SOURCE   = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned CNT_W          = 16
) (
  input logic               CLK,
  input logic               rst_n,
  fwd_hazard_unit_if.slave  bus
);

  localparam int unsigned BcntInitInt = (LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0;
  localparam logic [2:0]  BcntInit    = 3'(BcntInitInt);

  logic [NUM_SRC-1:0]   lu_match;
  logic [2*NUM_SRC-1:0] fwd;
  logic                 lu_det, freeze, stall;
  hz_state_e            state_q, state_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [CNT_W-1:0]     cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(
      .WIDTH_SOURCE (WIDTH_SOURCE)
    ) u_sel (
      .ex_rs         (bus.ID_EX_rs[i*WIDTH_SOURCE +: WIDTH_SOURCE]),
      .ex_mem_rd     (bus.EX_MEM_rd),
      .ex_mem_reg_wr (bus.EX_MEM_Reg_Wr),
      .mem_wb_rd     (bus.MEM_WB_rd),
      .mem_wb_reg_wr (bus.MEM_WB_Reg_Wr),
      .id_rs         (bus.ID_rs[i*WIDTH_SOURCE +: WIDTH_SOURCE]),
      .id_rs_used    (bus.ID_rs_used[i]),
      .id_ex_rd      (bus.ID_EX_rd),
      .fwd_sel       (fwd[2*i +: 2]),
      .lu_match      (lu_match[i])
    );
  end

  assign bus.Forward = fwd;

  assign lu_det = bus.ID_EX_Mem_Rd && bus.ID_EX_Reg_Wr && (|lu_match);
  assign freeze = bus.EX_MEM_Mem_Acc && !bus.mem_ready;

  // Freeze holds the FSM in place so an interrupted bubble run resumes exactly.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    stall   = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        StIdle: begin
          if (lu_det) begin
            stall = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = StLuStall;
              bcnt_d  = BcntInit;
            end
          end
        end
        StLuStall: begin
          stall = 1'b1;
          if (bcnt_q == 3'd0) begin
            state_d = StIdle;
          end else begin
            bcnt_d = bcnt_q - 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.stall_cnt_clr) begin
      cnt_q <= '0;
    end else if ((stall || freeze) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gating with rst_n drops the stall controls asynchronously during reset.
  assign bus.PC_Stall    = rst_n & stall;
  assign bus.IF_ID_Stall = rst_n & stall;
  assign bus.ID_EX_Flush = rst_n & stall;
  assign bus.Pipe_Freeze = rst_n & freeze;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: unit A (2 src, 1 bubble, 16-bit cnt), unit B (3 src, 3 bubbles, 4-bit cnt).
module tb_fwd_hazard_unit;

  typedef struct {
    string       tag;
    bit          unit_b;
    logic [5:0]  fwd;
    logic        stall;
    logic        frz;
    bit          chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  logic CLK;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t e_cur;

  fwd_hazard_unit_if #(.WIDTH_SOURCE(5), .NUM_SRC(2), .CNT_W(16)) ifa ();
  fwd_hazard_unit_if #(.WIDTH_SOURCE(5), .NUM_SRC(3), .CNT_W(4))  ifb ();

  fwd_hazard_unit #(
    .WIDTH_SOURCE(5), .NUM_SRC(2), .LOAD_STALL_CYC(1), .CNT_W(16)
  ) u_dut_a (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  fwd_hazard_unit #(
    .WIDTH_SOURCE(5), .NUM_SRC(3), .LOAD_STALL_CYC(3), .CNT_W(4)
  ) u_dut_b (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] fwd_ref(input int n, input logic [14:0] rs,
                                         input logic [4:0] exm, input logic exw,
                                         input logic [4:0] mwb, input logic mww);
    logic [5:0] r;
    logic [4:0] s;
    r = '0;
    for (int i = 0; i < n; i++) begin
      s = rs[i*5 +: 5];
      if (exw && exm != 5'd0 && exm == s) r[i*2 +: 2] = 2'b10;
      else if (mww && mwb != 5'd0 && mwb == s) r[i*2 +: 2] = 2'b01;
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      e_cur = sb_q.pop_front();
      if (!e_cur.unit_b) begin
        check_value({e_cur.tag, ".fwd"},   32'(ifa.Forward),     32'(e_cur.fwd));
        check_value({e_cur.tag, ".pc"},    32'(ifa.PC_Stall),    32'(e_cur.stall));
        check_value({e_cur.tag, ".ifid"},  32'(ifa.IF_ID_Stall), 32'(e_cur.stall));
        check_value({e_cur.tag, ".flush"}, 32'(ifa.ID_EX_Flush), 32'(e_cur.stall));
        check_value({e_cur.tag, ".frz"},   32'(ifa.Pipe_Freeze), 32'(e_cur.frz));
        if (e_cur.chk_cnt) check_value({e_cur.tag, ".cnt"}, 32'(ifa.stall_cnt), 32'(e_cur.cnt));
      end else begin
        check_value({e_cur.tag, ".fwd"},   32'(ifb.Forward),     32'(e_cur.fwd));
        check_value({e_cur.tag, ".pc"},    32'(ifb.PC_Stall),    32'(e_cur.stall));
        check_value({e_cur.tag, ".ifid"},  32'(ifb.IF_ID_Stall), 32'(e_cur.stall));
        check_value({e_cur.tag, ".flush"}, 32'(ifb.ID_EX_Flush), 32'(e_cur.stall));
        check_value({e_cur.tag, ".frz"},   32'(ifb.Pipe_Freeze), 32'(e_cur.frz));
        if (e_cur.chk_cnt) check_value({e_cur.tag, ".cnt"}, 32'(ifb.stall_cnt), 32'(e_cur.cnt));
      end
    end
  end

  task automatic idle_a();
    ifa.ID_rs = '0; ifa.ID_rs_used = '0; ifa.ID_EX_rs = '0; ifa.ID_EX_rd = '0;
    ifa.ID_EX_Reg_Wr = 0; ifa.ID_EX_Mem_Rd = 0; ifa.EX_MEM_rd = '0; ifa.EX_MEM_Reg_Wr = 0;
    ifa.EX_MEM_Mem_Acc = 0; ifa.MEM_WB_rd = '0; ifa.MEM_WB_Reg_Wr = 0; ifa.mem_ready = 1;
    ifa.stall_cnt_clr = 0;
  endtask

  task automatic idle_b();
    ifb.ID_rs = '0; ifb.ID_rs_used = '0; ifb.ID_EX_rs = '0; ifb.ID_EX_rd = '0;
    ifb.ID_EX_Reg_Wr = 0; ifb.ID_EX_Mem_Rd = 0; ifb.EX_MEM_rd = '0; ifb.EX_MEM_Reg_Wr = 0;
    ifb.EX_MEM_Mem_Acc = 0; ifb.MEM_WB_rd = '0; ifb.MEM_WB_Reg_Wr = 0; ifb.mem_ready = 1;
    ifb.stall_cnt_clr = 0;
  endtask

  task automatic push_exp(input string tag, input bit unit_b, input logic stall,
                          input logic frz, input int cnt);
    exp_t e;
    e.tag     = tag;
    e.unit_b  = unit_b;
    e.fwd     = unit_b ?
        fwd_ref(3, ifb.ID_EX_rs, ifb.EX_MEM_rd, ifb.EX_MEM_Reg_Wr, ifb.MEM_WB_rd,
                ifb.MEM_WB_Reg_Wr) :
        fwd_ref(2, {5'd0, ifa.ID_EX_rs}, ifa.EX_MEM_rd, ifa.EX_MEM_Reg_Wr, ifa.MEM_WB_rd,
                ifa.MEM_WB_Reg_Wr);
    e.stall   = stall;
    e.frz     = frz;
    e.chk_cnt = (cnt >= 0);
    e.cnt     = 16'(cnt);
    sb_q.push_back(e);
  endtask

  task automatic step_a(input string tag, input logic stall, input logic frz, input int cnt);
    push_exp(tag, 1'b0, stall, frz, cnt);
    @(posedge CLK); #1;
  endtask

  task automatic step_b(input string tag, input logic stall, input logic frz, input int cnt);
    push_exp(tag, 1'b1, stall, frz, cnt);
    @(posedge CLK); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    #12 rst_n = 1'b1;
    @(posedge CLK); #1;

    // Unit A: forwarding
    step_a("a_reset", 0, 0, 0);
    ifa.EX_MEM_Reg_Wr = 1; ifa.EX_MEM_rd = 5; ifa.MEM_WB_Reg_Wr = 1; ifa.MEM_WB_rd = 5;
    ifa.ID_EX_rs = {5'd5, 5'd5};
    #1 check_value("a_fwd_prio", 32'(ifa.Forward), 32'h0000_000a);
    step_a("a_fwd_prio_sb", 0, 0, 0);
    ifa.EX_MEM_rd = 0; ifa.MEM_WB_rd = 0; ifa.ID_EX_rs = '0;
    #1 check_value("a_fwd_x0", 32'(ifa.Forward), 32'h0);
    step_a("a_fwd_x0_sb", 0, 0, 0);
    ifa.EX_MEM_rd = 8; ifa.MEM_WB_rd = 3; ifa.ID_EX_rs = {5'd8, 5'd3};
    #1 check_value("a_fwd_mix", 32'(ifa.Forward), 32'h0000_0009);
    step_a("a_fwd_mix_sb", 0, 0, 0);
    ifa.EX_MEM_Reg_Wr = 0; ifa.EX_MEM_rd = 3; ifa.MEM_WB_rd = 3; ifa.ID_EX_rs = {5'd3, 5'd3};
    #1 check_value("a_fwd_nowr", 32'(ifa.Forward), 32'h0000_0005);
    step_a("a_fwd_nowr_sb", 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      ifa.EX_MEM_Reg_Wr = 1'($urandom_range(0, 1));
      ifa.MEM_WB_Reg_Wr = 1'($urandom_range(0, 1));
      ifa.EX_MEM_rd     = 5'($urandom_range(0, 3));
      ifa.MEM_WB_rd     = 5'($urandom_range(0, 3));
      ifa.ID_EX_rs      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      step_a("a_fwd_rand", 0, 0, 0);
    end

    // Unit A: single-bubble load-use
    idle_a();
    ifa.ID_EX_Mem_Rd = 1; ifa.ID_EX_Reg_Wr = 1; ifa.ID_EX_rd = 4;
    ifa.ID_rs = {5'd0, 5'd4}; ifa.ID_rs_used = 2'b01;
    step_a("a_lu_src0", 1, 0, 0);
    idle_a();
    step_a("a_lu_after", 0, 0, 1);
    step_a("a_lu_idle", 0, 0, 1);
    ifa.ID_EX_Mem_Rd = 1; ifa.ID_EX_Reg_Wr = 1; ifa.ID_EX_rd = 4;
    ifa.ID_rs = {5'd0, 5'd4}; ifa.ID_rs_used = 2'b00;
    step_a("a_lu_unused", 0, 0, 1);
    ifa.ID_rs = {5'd4, 5'd0}; ifa.ID_rs_used = 2'b10;
    step_a("a_lu_src1", 1, 0, 1);
    idle_a();
    step_a("a_lu_src1_after", 0, 0, 2);
    ifa.ID_EX_Mem_Rd = 1; ifa.ID_EX_Reg_Wr = 1; ifa.ID_EX_rd = 0;
    ifa.ID_rs = '0; ifa.ID_rs_used = 2'b11;
    step_a("a_lu_x0", 0, 0, 2);
    ifa.ID_EX_rd = 4; ifa.ID_rs = {5'd0, 5'd4}; ifa.ID_rs_used = 2'b01;
    ifa.EX_MEM_Mem_Acc = 1; ifa.mem_ready = 0;
    step_a("a_frz_lu", 0, 1, 2);
    ifa.mem_ready = 1;
    step_a("a_lu_resume", 1, 0, 3);
    idle_a();
    step_a("a_lu_resume_after", 0, 0, 4);
    ifa.stall_cnt_clr = 1;
    step_a("a_clr", 0, 0, 4);
    ifa.stall_cnt_clr = 0;
    step_a("a_clr_after", 0, 0, 0);

    // Unit B: three-source forwarding
    ifb.EX_MEM_Reg_Wr = 1; ifb.EX_MEM_rd = 9; ifb.MEM_WB_Reg_Wr = 1; ifb.MEM_WB_rd = 7;
    ifb.ID_EX_rs = {5'd7, 5'd3, 5'd9};
    #1 check_value("b_fwd3", 32'(ifb.Forward), 32'h0000_0012);
    step_b("b_fwd3_sb", 0, 0, 0);

    // Unit B: three bubbles interrupted by a two-cycle freeze
    idle_b();
    ifb.ID_EX_Mem_Rd = 1; ifb.ID_EX_Reg_Wr = 1; ifb.ID_EX_rd = 4;
    ifb.ID_rs = {5'd0, 5'd0, 5'd4}; ifb.ID_rs_used = 3'b001;
    step_b("b_lu0", 1, 0, 0);
    idle_b();
    ifb.EX_MEM_Mem_Acc = 1; ifb.mem_ready = 0;
    step_b("b_frz1", 0, 1, 1);
    step_b("b_frz2", 0, 1, 2);
    ifb.EX_MEM_Mem_Acc = 0; ifb.mem_ready = 1;
    step_b("b_lu1", 1, 0, 3);
    step_b("b_lu2", 1, 0, 4);
    step_b("b_done", 0, 0, 5);

    // Unit B: 4-bit counter saturation and clear priority
    ifb.stall_cnt_clr = 1;
    step_b("b_pre_clr", 0, 0, 5);
    ifb.stall_cnt_clr = 0; ifb.EX_MEM_Mem_Acc = 1; ifb.mem_ready = 0;
    for (int k = 0; k < 20; k++) step_b("b_sat", 0, 1, (k > 15) ? 15 : k);
    ifb.stall_cnt_clr = 1;
    step_b("b_clr_frz", 0, 1, 15);
    idle_b();
    step_b("b_after_clr", 0, 0, 0);

    // Unit B: reset in LU_STALL with bcnt=1
    ifb.ID_EX_Mem_Rd = 1; ifb.ID_EX_Reg_Wr = 1; ifb.ID_EX_rd = 6;
    ifb.ID_rs = {5'd6, 5'd0, 5'd0}; ifb.ID_rs_used = 3'b100;
    step_b("b_lu_pre", 1, 0, 0);
    idle_b();
    check_value("b_lu_hold", 32'(ifb.PC_Stall), 32'h1);
    rst_n = 1'b0;
    #1 check_value("b_rst_pc", 32'(ifb.PC_Stall), 32'h0);
    check_value("b_rst_flush", 32'(ifb.ID_EX_Flush), 32'h0);
    push_exp("b_in_rst", 1'b1, 0, 0, 0);
    @(negedge CLK); #2;
    rst_n = 1'b1;
    @(posedge CLK); #1;
    step_b("b_post_rst0", 0, 0, 0);
    step_b("b_post_rst1", 0, 0, 0);
    step_b("b_post_rst2", 0, 0, 0);

    @(negedge CLK); #1;
    check_value("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised next-generation operand forwarding and hazard control for the RV32I pipeline.
- Generates per-source forwarding selects for NUM_SRC operands, with priority EX/MEM over MEM/WB.
- Detects load-use hazards and inserts a parametrised number of bubbles using a countdown FSM.
- Freezes the whole pipeline while data memory is not ready, and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- WIDTH_SOURCE, 5, register index width.
- NUM_SRC, 2, number of source operands checked (3 for future FMA/store-data use).
- LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (1..7); equals load-to-use latency minus 1.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ID_rs  in  NUM_SRC*WIDTH_SOURCE  sources of the instruction in ID; slice i = source i
- ID_rs_used  in  NUM_SRC  source i actually read by the ID instruction
- ID_EX_rs  in  NUM_SRC*WIDTH_SOURCE  sources of the instruction in EX
- ID_EX_rd  in  WIDTH_SOURCE  EX destination
- ID_EX_Reg_Wr  in  1  EX instruction writes rd
- ID_EX_Mem_Rd  in  1  EX instruction is a load
- EX_MEM_rd  in  WIDTH_SOURCE  MEM destination
- EX_MEM_Reg_Wr  in  1  MEM instruction writes rd
- EX_MEM_Mem_Acc  in  1  MEM instruction accesses data memory
- MEM_WB_rd  in  WIDTH_SOURCE  WB destination
- MEM_WB_Reg_Wr  in  1  WB instruction writes rd
- mem_ready  in  1  data memory completes access this cycle
- stall_cnt_clr  in  1  synchronous clear of stall_cnt
- Forward  out  2*NUM_SRC  per-source select; slice i: 00 regfile, 01 MEM/WB, 10 EX/MEM
- PC_Stall  out  1  hold PC
- IF_ID_Stall  out  1  hold IF/ID register
- ID_EX_Flush  out  1  load bubble into ID/EX
- Pipe_Freeze  out  1  hold all pipeline registers, no flush
- stall_cnt  out  CNT_W  cycles with stall or freeze asserted

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, bubble counter 0 and stall_cnt 0. PC_Stall, IF_ID_Stall, ID_EX_Flush and Pipe_Freeze are 0 while rst_n is low. Forward stays purely combinational.
- Forwarding, per source i, zero latency:
  - 10 if EX_MEM_Reg_Wr, EX_MEM_rd != 0 and EX_MEM_rd == ID_EX_rs[i].
  - Otherwise 01 if MEM_WB_Reg_Wr, MEM_WB_rd != 0 and MEM_WB_rd == ID_EX_rs[i].
  - Otherwise 00.
  - x0 is never forwarded.
- Load-use detect (lu_det), combinational: ID_EX_Mem_Rd, ID_EX_Reg_Wr, ID_EX_rd != 0, and some i with ID_rs_used[i] and ID_rs[i] == ID_EX_rd.
- Freeze: Pipe_Freeze = EX_MEM_Mem_Acc & !mem_ready, same cycle. It has priority over everything: while frozen, PC_Stall, IF_ID_Stall and ID_EX_Flush are 0 and the FSM and bubble counter hold.
- FSM states: IDLE and LU_STALL. The bubble counter bcnt is 3 bits.
  - IDLE, lu_det & !freeze: assert PC_Stall, IF_ID_Stall and ID_EX_Flush this cycle. If LOAD_STALL_CYC > 1, go to LU_STALL with bcnt = LOAD_STALL_CYC-2; otherwise stay in IDLE.
  - LU_STALL, !freeze: assert all three stall outputs. If bcnt == 0, go to IDLE; else decrement bcnt.
  - LU_STALL ignores lu_det, since ID_EX holds a bubble.
  - Total bubbles per hazard is exactly LOAD_STALL_CYC unfrozen cycles.
- Freeze arriving mid-LU_STALL: the bubble sequence resumes where it stopped once mem_ready rises; no bubble is lost or duplicated.
- stall_cnt:
  - Increments by 1 on each clock where (PC_Stall | Pipe_Freeze) is 1.
  - Saturates at 2^CNT_W-1.
  - stall_cnt_clr has priority over increment and loads 0.
- Reset asserted mid-stall: state returns to IDLE immediately, outputs drop asynchronously, and no pending bubbles are kept.

Decomposition:
- Shared package fwd_pkg holds:
  - Forward encodings FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - FSM state encoding.
  - REG_X0 constant.
- Sub-module fwd_src_sel: one source comparator producing the 2-bit select and the per-source load-use match. It is instantiated NUM_SRC times in a generate loop.
- The top level holds the FSM, freeze logic and counter.

Test Plan:
- EX_MEM_Reg_Wr=1, EX_MEM_rd=5, MEM_WB_Reg_Wr=1, MEM_WB_rd=5, ID_EX_rs={5,5} -> Forward={10,10}. With EX_MEM_rd=0 and MEM_WB_rd=0, ID_EX_rs={0,0} -> Forward={00,00}.
- NUM_SRC=3, ID_EX_rs={7,3,9}, EX_MEM_rd=9, MEM_WB_rd=7 (both Reg_Wr=1) -> Forward = {01,00,10} (slice 2..0).
- LOAD_STALL_CYC=1: load with ID_EX_rd=4, ID_rs[0]=4 used -> stalls/flush high exactly 1 cycle, state stays IDLE, stall_cnt=1. Same case with ID_rs_used[0]=0 -> no stall.
- LOAD_STALL_CYC=3: hazard detected, then mem_ready=0 with EX_MEM_Mem_Acc=1 for 2 cycles after the first bubble -> sequence is stall, freeze, freeze, stall, stall; stall_cnt=5.
- stall_cnt saturation (CNT_W=4): 20 stall cycles -> stall_cnt=15; stall_cnt_clr pulse coincident with a stall -> 0.
- rst_n deasserted to 0 during LU_STALL with bcnt=1 -> outputs 0 immediately. After release, no further bubbles without a new lu_det.
